// File: rtl/bp_io_cmd_arbiter_pkg.sv
// bp_io_cmd_arbiter_pkg: shared sizing helper for the IO command arbiter and its order FIFO.
package bp_io_cmd_arbiter_pkg;

    // Index width that stays at least one bit, so single-entry configurations still elaborate.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small: small one-read one-write FIFO with valid/ready in and valid/yumi out.
// Ports: clk_i, reset_i (async, active high); data_i/v_i/ready_o enqueue side;
//        data_o/v_o/yumi_i dequeue side (yumi_i only while v_o is high).
module bsg_fifo_1r1w_small
    import bp_io_cmd_arbiter_pkg::*;
#(
    parameter int width_p = 1,
    parameter int els_p   = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int pw = safe_clog2(els_p);
    localparam int cw = $clog2(els_p + 1);

    logic [width_p-1:0] mem [els_p];
    logic [pw-1:0]      rptr, wptr;
    logic [cw-1:0]      count;
    logic               enq, deq;

    assign ready_o = count != cw'(els_p);
    assign v_o     = count != '0;
    assign data_o  = mem[rptr];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    // Pointers wrap explicitly so depths that are not a power of two work.
    function automatic logic [pw-1:0] bump(input logic [pw-1:0] p);
        return (p == pw'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (enq) wptr <= bump(wptr);
            if (deq) rptr <= bump(rptr);
            count <= count + cw'(enq) - cw'(deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr] <= data_i;
    end

endmodule

// File: rtl/bp_io_cmd_arbiter.sv
// bp_io_cmd_arbiter: round-robin arbiter sharing one credit-limited IO link among requesters,
// steering responses back in issue order.
// Ports: clk_i, reset_i (async, active high);
//        req_cmd_i/req_cmd_v_i/req_cmd_ready_o   per-requester commands in;
//        io_cmd_o/io_cmd_v_o/io_cmd_ready_i      arbitrated command to the link;
//        io_resp_i/io_resp_v_i/io_resp_yumi_o    responses from the link;
//        req_resp_o/req_resp_v_o/req_resp_yumi_i responses steered to the issuing requester;
//        credits_o outstanding commands; error_o sticky unexpected-response flag.
module bp_io_cmd_arbiter
    import bp_io_cmd_arbiter_pkg::*;
#(
    parameter int num_req_p     = 2,
    parameter int max_credits_p = 8,
    parameter int msg_width_p   = 128
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [num_req_p-1:0][msg_width_p-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]                  req_cmd_v_i,
    output logic [num_req_p-1:0]                  req_cmd_ready_o,
    output logic [msg_width_p-1:0]                io_cmd_o,
    output logic                                  io_cmd_v_o,
    input  logic                                  io_cmd_ready_i,
    input  logic [msg_width_p-1:0]                io_resp_i,
    input  logic                                  io_resp_v_i,
    output logic                                  io_resp_yumi_o,
    output logic [msg_width_p-1:0]                req_resp_o,
    output logic [num_req_p-1:0]                  req_resp_v_o,
    input  logic [num_req_p-1:0]                  req_resp_yumi_i,
    output logic [$clog2(max_credits_p+1)-1:0]    credits_o,
    output logic                                  error_o
);
    localparam int iw = safe_clog2(num_req_p);
    localparam int cw = $clog2(max_credits_p + 1);

    logic [iw-1:0] ptr, winner, head;
    logic          cmd_hs, head_v, fifo_ready, fifo_v;

    // Scan downward so the requester closest above ptr is the last (winning) assignment.
    always_comb begin
        winner = ptr;
        for (int k = num_req_p - 1; k >= 0; k--)
            if (req_cmd_v_i[(int'(ptr) + k) % num_req_p]) winner = iw'((int'(ptr) + k) % num_req_p);
    end

    // Credits are checked against the registered count only; a same-cycle pop does not free a slot.
    // The FIFO ready tracks the credit count exactly and is kept as a safety gate.
    assign io_cmd_v_o      = ~reset_i & (|req_cmd_v_i) & (credits_o < cw'(max_credits_p)) & fifo_ready;
    assign io_cmd_o        = req_cmd_i[winner];
    assign cmd_hs          = io_cmd_v_o & io_cmd_ready_i;
    assign req_cmd_ready_o = cmd_hs ? (num_req_p)'(1'b1) << winner : '0;

    assign head_v          = ~reset_i & io_resp_v_i & fifo_v;
    assign req_resp_o      = io_resp_i;
    assign req_resp_v_o    = head_v ? (num_req_p)'(1'b1) << head : '0;
    assign io_resp_yumi_o  = head_v & req_resp_yumi_i[head];

    bsg_fifo_1r1w_small #(
        .width_p(iw),
        .els_p  (max_credits_p)
    ) order_fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .data_i (winner),
        .v_i    (cmd_hs),
        .ready_o(fifo_ready),
        .v_o    (fifo_v),
        .data_o (head),
        .yumi_i (io_resp_yumi_o)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr       <= '0;
            credits_o <= '0;
            error_o   <= 1'b0;
        end else begin
            if (cmd_hs) ptr <= (winner == iw'(num_req_p - 1)) ? '0 : winner + 1'b1;
            if (cmd_hs & ~io_resp_yumi_o) credits_o <= credits_o + 1'b1;
            else if (~cmd_hs & io_resp_yumi_o) credits_o <= credits_o - 1'b1;
            if (io_resp_v_i & ~fifo_v) error_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// tb_bp_io_cmd_arbiter: self-checking bench for bp_io_cmd_arbiter.
module tb_bp_io_cmd_arbiter;
    localparam int N = 2;
    localparam int C = 8;
    localparam int W = 128;

    logic                clk = 1'b0;
    logic                reset_i;
    logic [N-1:0][W-1:0] req_cmd;
    logic [N-1:0]        cmd_v, cmd_ready, req_resp_v, req_yumi;
    logic [W-1:0]        io_cmd, io_resp, req_resp;
    logic                io_cmd_v, io_rdy, resp_v, resp_yumi, error;
    logic [3:0]          credits;

    int       checks = 0;
    int       failures = 0;
    int       q[$];
    int       mptr, mcred;
    bit       merr;
    logic       last_cmd_v, last_yumi;
    logic [1:0] last_ready, last_rv;

    typedef struct {
        logic [1:0] v;
        logic       rdy;
        logic [1:0] exp_ready;
        int         exp_cred;
    } vec_t;
    vec_t       tbl[8];
    logic [1:0] steer[3];

    always #5 clk = ~clk;

    bp_io_cmd_arbiter #(.num_req_p(N), .max_credits_p(C), .msg_width_p(W)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_cmd_i(req_cmd), .req_cmd_v_i(cmd_v), .req_cmd_ready_o(cmd_ready),
        .io_cmd_o(io_cmd), .io_cmd_v_o(io_cmd_v), .io_cmd_ready_i(io_rdy),
        .io_resp_i(io_resp), .io_resp_v_i(resp_v), .io_resp_yumi_o(resp_yumi),
        .req_resp_o(req_resp), .req_resp_v_o(req_resp_v), .req_resp_yumi_i(req_yumi),
        .credits_o(credits), .error_o(error)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive at posedge+1, compare against the reference model at +3,
    // then advance the model at the next posedge. Issued requester ids are pushed
    // into the scoreboard queue and popped when the DUT consumes a response.
    task automatic step(input logic [1:0] v, input logic rdy, input logic rv, input logic [1:0] ry);
        int win;
        bit mv, hs, yu, orphan;
        logic [1:0] erv;
        cmd_v = v; io_rdy = rdy; resp_v = rv; req_yumi = ry; io_resp = W'($urandom);
        win = mptr;
        for (int k = N - 1; k >= 0; k--) if (v[(mptr + k) % N]) win = (mptr + k) % N;
        mv = (v != 0) && (mcred < C);
        hs = mv && rdy;
        yu = rv && (q.size() > 0) && ry[q[0]];
        erv = (rv && q.size() > 0) ? 2'(1 << q[0]) : 2'b00;
        orphan = rv && (q.size() == 0);
        #2;
        last_cmd_v = io_cmd_v; last_yumi = resp_yumi; last_ready = cmd_ready; last_rv = req_resp_v;
        chk("cmd_v", io_cmd_v, mv);
        if (mv) chk("cmd_data", io_cmd, req_cmd[win]);
        chk("cmd_ready", cmd_ready, hs ? 2'(1 << win) : 2'b00);
        chk("resp_v", req_resp_v, erv);
        chk("resp_yumi", resp_yumi, yu);
        chk("resp_data", req_resp, io_resp);
        chk("credits", credits, mcred);
        chk("error", error, merr);
        @(posedge clk);
        if (yu) void'(q.pop_front());
        if (hs) begin
            q.push_back(win);
            mptr = (win + 1) % N;
        end
        mcred = mcred + int'(hs) - int'(yu);
        if (orphan) merr = 1;
        #1;
    endtask

    initial begin
        tbl[0] = '{2'b11, 1'b1, 2'b01, 0};
        tbl[1] = '{2'b11, 1'b1, 2'b10, 1};
        tbl[2] = '{2'b11, 1'b1, 2'b01, 2};
        tbl[3] = '{2'b11, 1'b1, 2'b10, 3};
        tbl[4] = '{2'b11, 1'b0, 2'b00, 4};
        tbl[5] = '{2'b10, 1'b1, 2'b10, 4};
        tbl[6] = '{2'b01, 1'b1, 2'b01, 5};
        tbl[7] = '{2'b00, 1'b1, 2'b00, 6};
        steer[0] = 2'b10; steer[1] = 2'b01; steer[2] = 2'b10;
        req_cmd[0] = {4{$urandom}};
        req_cmd[1] = {4{$urandom}};
        mptr = 0; mcred = 0; merr = 0;

        reset_i = 1'b1; cmd_v = 2'b11; io_rdy = 1'b1; resp_v = 1'b1; req_yumi = 2'b11; io_resp = '0;
        #12;
        chk("rst_cmd_v", io_cmd_v, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 2'b00);
        chk("rst_resp_v", req_resp_v, 2'b00);
        chk("rst_yumi", resp_yumi, 1'b0);
        chk("rst_credits", credits, 4'd0);
        chk("rst_error", error, 1'b0);
        cmd_v = '0; io_rdy = 1'b0; resp_v = 1'b0; req_yumi = '0;
        reset_i = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].rdy, 1'b0, 2'b00);
            chk("tbl_ready", last_ready, tbl[i].exp_ready);
            if (i == 3) chk("rr_credits4", credits, 4'd4);
        end

        step(2'b01, 1'b1, 1'b0, 2'b00);
        step(2'b10, 1'b1, 1'b0, 2'b00);
        chk("full_credits", credits, 4'd8);
        step(2'b11, 1'b1, 1'b0, 2'b00);
        chk("full_block", last_cmd_v, 1'b0);
        step(2'b11, 1'b1, 1'b1, 2'b10);
        chk("nonhead_yumi", last_yumi, 1'b0);
        step(2'b11, 1'b1, 1'b1, 2'b01);
        chk("no_bypass", last_cmd_v, 1'b0);
        chk("pop_at_full", last_yumi, 1'b1);
        step(2'b11, 1'b1, 1'b0, 2'b00);
        chk("reissue", last_cmd_v, 1'b1);

        while (mcred > 3) step(2'b00, 1'b0, 1'b1, 2'b11);
        step(2'b11, 1'b1, 1'b1, 2'b11);
        chk("same_cycle", credits, 4'd3);
        while (mcred > 0) step(2'b00, 1'b0, 1'b1, 2'b11);

        step(2'b10, 1'b1, 1'b0, 2'b00);
        step(2'b01, 1'b1, 1'b0, 2'b00);
        step(2'b10, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 1'b0, 1'b1, 2'b11);
            chk("steer", last_rv, steer[i]);
        end

        for (int i = 0; i < 5; i++) step(2'b11, 1'b1, 1'b0, 2'b00);
        chk("pre_reset_credits", credits, 4'd5);
        cmd_v = 2'b11; io_rdy = 1'b1; resp_v = 1'b1; req_yumi = 2'b11;
        #2 reset_i = 1'b1;
        #1;
        chk("async_credits", credits, 4'd0);
        chk("async_cmd_v", io_cmd_v, 1'b0);
        chk("async_cmd_ready", cmd_ready, 2'b00);
        chk("async_resp_v", req_resp_v, 2'b00);
        chk("async_yumi", resp_yumi, 1'b0);
        chk("async_error", error, 1'b0);
        #1 reset_i = 1'b0;
        cmd_v = '0; io_rdy = 1'b0; resp_v = 1'b0; req_yumi = '0;
        @(posedge clk); #1;
        q.delete(); mptr = 0; mcred = 0; merr = 0;

        step(2'b00, 1'b0, 1'b1, 2'b11);
        chk("orphan_yumi", last_yumi, 1'b0);
        step(2'b00, 1'b0, 1'b0, 2'b00);
        chk("orphan_error", error, 1'b1);

        for (int i = 0; i < 300; i++)
            step(2'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bp_io_cmd_arbiter.md
BP_IO_CMD_ARBITER -- requirements
Module: bp_io_cmd_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 2: number of IO command requesters sharing one IO link.
REQ-002 SHALL have parameter max_credits_p, default 8: maximum outstanding IO commands, matching io_noc_max_credits_p.
REQ-003 SHALL have parameter msg_width_p, default 128: width of a packed bp_cce_mem_msg_s.
REQ-004 SHALL have port clk_i, input, 1: the single clock.
REQ-005 SHALL have port reset_i, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port req_cmd_i, input, num_req_p x msg_width_p: per-requester command.
REQ-007 SHALL have port req_cmd_v_i, input, num_req_p: per-requester command valid.
REQ-008 SHALL have port req_cmd_ready_o, output, num_req_p: per-requester command accept.
REQ-009 SHALL have port io_cmd_o, output, msg_width_p: command to the link.
REQ-010 SHALL have port io_cmd_v_o, output, 1: command valid.
REQ-011 SHALL have port io_cmd_ready_i, input, 1: link ready.
REQ-012 SHALL have port io_resp_i, input, msg_width_p: response from the link.
REQ-013 SHALL have port io_resp_v_i, input, 1: response valid.
REQ-014 SHALL have port io_resp_yumi_o, output, 1: response consumed.
REQ-015 SHALL have port req_resp_o, output, msg_width_p: io_resp_i broadcast to all requesters.
REQ-016 SHALL have port req_resp_v_o, output, num_req_p: one-hot response valid.
REQ-017 SHALL have port req_resp_yumi_i, input, num_req_p: per-requester response consume.
REQ-018 SHALL have port credits_o, output, $clog2(max_credits_p+1): outstanding command count.
REQ-019 SHALL have port error_o, output, 1: sticky error for a response received with no outstanding command.

Function
REQ-020 SHALL pick a round-robin winner among asserted req_cmd_v_i bits, searching from priority pointer ptr upward with wrap at num_req_p-1.
REQ-021 SHALL drive io_cmd_v_o = (|req_cmd_v_i) & (credits_o < max_credits_p) and io_cmd_o = req_cmd_i[winner], combinationally with zero latency.
REQ-022 SHALL assert req_cmd_ready_o[i] only when i == winner, io_cmd_ready_i = 1 and credits are available; all other bits SHALL be 0.
REQ-023 SHALL, on a cmd handshake (io_cmd_v_o & io_cmd_ready_i), set ptr to winner+1 mod num_req_p and push winner into the order FIFO; ptr SHALL otherwise hold.
REQ-024 SHALL keep the order FIFO depth at max_credits_p, so it never overflows while credits gate issue.
REQ-025 SHALL, while io_resp_v_i = 1 and the FIFO is non-empty, assert req_resp_v_o[head] only; io_resp_yumi_o SHALL equal req_resp_yumi_i[head].
REQ-026 SHALL, on io_resp_yumi_o, pop the FIFO.
REQ-027 SHALL update credits_o by +1 on a cmd handshake, -1 on io_resp_yumi_o, and leave it unchanged when both occur in the same cycle.
REQ-028 SHALL allow a cmd at credits_o = max_credits_p-1 together with a same-cycle resp pop.
REQ-029 SHALL block issue when credits_o = max_credits_p, even if a resp pops in that cycle (no combinational credit bypass).
REQ-030 SHALL, on io_resp_v_i with the FIFO empty, hold io_resp_yumi_o = 0, hold req_resp_v_o = 0 and set error_o until reset.
REQ-031 SHALL ignore req_resp_yumi_i bits that are not the head.
REQ-032 SHALL tolerate a requester dropping req_cmd_v_i before its grant; the arbiter holds no lock.

Reset
REQ-033 SHALL, on reset_i assertion (asynchronous), clear ptr, credits_o, the FIFO and error_o.
REQ-034 SHALL, during reset, force io_cmd_v_o, req_cmd_ready_o, req_resp_v_o and io_resp_yumi_o to 0.
REQ-035 SHALL, on reset mid-operation, discard outstanding state; responses arriving after reset are treated per REQ-030.

Structure
REQ-036 SHALL take bp_cce_mem_msg_s and io_noc_max_credits_p from the shared bp_me_pkg/bp_common parameter macros; no new package types.
REQ-037 SHALL implement the order FIFO as one sub-module, bsg_fifo_1r1w_small, of width $clog2(num_req_p) and depth max_credits_p.

Verification
REQ-038 SHALL cover: both requesters valid for 4 cycles with ready=1 -> grants 0,1,0,1 and credits_o reaches 4.
REQ-039 SHALL cover: 8 cmds with no resp -> io_cmd_v_o=0 at credits_o=8; one resp yumi -> next cmd issues the following cycle.
REQ-040 SHALL cover: cmds from req 1,0,1 -> responses steered req_resp_v_o = 2'b10, 2'b01, 2'b10 in that order.
REQ-041 SHALL cover: cmd handshake and resp yumi in the same cycle at credits_o=3 -> credits_o stays 3.
REQ-042 SHALL cover: io_resp_v_i with credits_o=0 -> error_o=1, io_resp_yumi_o=0.
REQ-043 SHALL cover: reset_i pulsed with credits_o=5 -> all outputs 0 and credits_o=0 immediately, asynchronously.
